// File: rtl/writeback_stage_pkg.sv
// Shared writeback-select codes, load funct3 constants and select classification
// helpers for the MEM/WB stage and its load extractor.
package writeback_stage_pkg;

    localparam int WB_MUX_SEL_WIDTH = 3;

    typedef enum logic [WB_MUX_SEL_WIDTH-1:0] {
        WB_ALU  = 3'd0,
        WB_MEM  = 3'd1,
        WB_PC   = 3'd2,
        WB_CSR  = 3'd3,
        WB_NULL = 3'd4
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Selects that produce a register-file write.
    function automatic logic wb_sel_writes(input logic [WB_MUX_SEL_WIDTH-1:0] sel);
        return (sel == WB_ALU) || (sel == WB_MEM) || (sel == WB_PC) || (sel == WB_CSR);
    endfunction

    function automatic logic wb_sel_known(input logic [WB_MUX_SEL_WIDTH-1:0] sel);
        return wb_sel_writes(sel) || (sel == WB_NULL);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB boundary bundle: stage control, registered sources, BRAM read data
// and the register-file write port.
interface writeback_stage_if
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    localparam int AW = $clog2(XLEN / 8);

    logic                        stall;
    logic                        flush;
    logic                        in_valid;
    logic [RA_W-1:0]             in_rd;
    logic [WB_MUX_SEL_WIDTH-1:0] in_sel;
    logic [2:0]                  in_funct3;
    logic [AW-1:0]               in_addr_lo;
    logic [XLEN-1:0]             in_alu_out;
    logic [XLEN-1:0]             in_pc_plus_4;
    logic [XLEN-1:0]             in_csr_dout;
    logic [XLEN-1:0]             mem_dout;

    logic                        wb_we;
    logic [RA_W-1:0]             wb_rd;
    logic [XLEN-1:0]             wb_data;
    logic                        sel_err;

    modport master (
        output stall, flush, in_valid, in_rd, in_sel, in_funct3, in_addr_lo,
               in_alu_out, in_pc_plus_4, in_csr_dout, mem_dout,
        input  wb_we, wb_rd, wb_data, sel_err
    );

    modport slave (
        input  stall, flush, in_valid, in_rd, in_sel, in_funct3, in_addr_lo,
               in_alu_out, in_pc_plus_4, in_csr_dout, mem_dout,
        output wb_we, wb_rd, wb_data, sel_err
    );

endinterface

// File: rtl/writeback_stage_load_extract.sv
// Combinational sub-word load extraction with sign/zero extension; shared with
// the uncached MMIO read path.
module load_extract
    import writeback_stage_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int AW   = $clog2(XLEN / 8)
) (
    input  logic [2:0]      funct3,
    input  logic [AW-1:0]   addr_lo,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] value,
    output logic            illegal
);

    logic [AW-1:0]   lo_h;
    logic [AW-1:0]   lo_w;
    logic [XLEN-1:0] lane_b;
    logic [XLEN-1:0] lane_h;
    logic [XLEN-1:0] lane_w;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        value   = '0;
        illegal = 1'b0;
        lo_h    = addr_lo & ~AW'(1);
        lo_w    = addr_lo & ~AW'(3);
        lane_b  = word >> {addr_lo, 3'b000};
        lane_h  = word >> {lo_h, 3'b000};
        lane_w  = word >> {lo_w, 3'b000};

        // Size casts of signed part-selects sign-extend; unsigned ones zero-extend.
        unique case (funct3)
            F3_LB:  value = XLEN'($signed(lane_b[7:0]));
            F3_LH:  value = XLEN'($signed(lane_h[15:0]));
            F3_LW:  value = XLEN'($signed(lane_w[31:0]));
            F3_LBU: value = XLEN'(lane_b[7:0]);
            F3_LHU: value = XLEN'(lane_h[15:0]);
            F3_LWU: value = XLEN'(lane_w[31:0]);
            F3_LD: begin
                if (XLEN == 64) value   = word;
                else            illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered MEM/WB stage: captures writeback control, selects the write source
// and holds BRAM load data across stalls so the register-file write stays stable.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  wb
);

    localparam int AW = $clog2(XLEN / 8);

    typedef struct packed {
        logic                        valid;
        logic [RA_W-1:0]             rd;
        logic [WB_MUX_SEL_WIDTH-1:0] sel;
        logic [2:0]                  funct3;
        logic [AW-1:0]               addr_lo;
        logic [XLEN-1:0]             alu;
        logic [XLEN-1:0]             pc4;
        logic [XLEN-1:0]             csr;
    } stage_t;

    stage_t          stage_q, stage_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic            hold_vld_q, hold_vld_d;
    logic            sel_err_q, sel_err_d;

    logic            stage_load;
    logic            is_mem;
    logic            err_now;
    logic [XLEN-1:0] ext_data;
    logic            ext_illegal;
    logic [XLEN-1:0] data_out;
    logic            we_out;

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .funct3  (stage_q.funct3),
        .addr_lo (stage_q.addr_lo),
        .word    (wb.mem_dout),
        .value   (ext_data),
        .illegal (ext_illegal)
    );

    always_comb begin
        stage_d     = stage_q;
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        data_out    = '0;
        we_out      = 1'b0;

        stage_load = !wb.stall || wb.flush;
        is_mem     = stage_q.valid && (stage_q.sel == WB_MEM);

        if (stage_load) begin
            stage_d.valid   = wb.in_valid && !wb.flush;
            stage_d.rd      = wb.in_rd;
            stage_d.sel     = wb.in_sel;
            stage_d.funct3  = wb.in_funct3;
            stage_d.addr_lo = wb.in_addr_lo;
            stage_d.alu     = wb.in_alu_out;
            stage_d.pc4     = wb.in_pc_plus_4;
            stage_d.csr     = wb.in_csr_dout;
        end

        // BRAM output is only trustworthy in the first stalled cycle; freeze it then.
        if (stage_load) begin
            hold_vld_d = 1'b0;
        end else if (is_mem && !hold_vld_q) begin
            hold_vld_d  = 1'b1;
            hold_data_d = ext_data;
        end

        err_now   = stage_q.valid &&
                    (!wb_sel_known(stage_q.sel) || ((stage_q.sel == WB_MEM) && ext_illegal));
        sel_err_d = sel_err_q || err_now;

        unique case (stage_q.sel)
            WB_ALU:  data_out = stage_q.alu;
            WB_PC:   data_out = stage_q.pc4;
            WB_CSR:  data_out = stage_q.csr;
            WB_MEM:  data_out = hold_vld_q ? hold_data_q : ext_data;
            default: data_out = '0;
        endcase

        we_out = stage_q.valid && wb_sel_writes(stage_q.sel) && (stage_q.rd != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q     <= '0;
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign wb.wb_we   = we_out;
    assign wb.wb_rd   = stage_q.rd;
    assign wb.wb_data = data_out;
    assign wb.sel_err = sel_err_q || err_now;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (XLEN=32): selects, load
// extraction, stall hold, flush, x0/NULL, sticky error and reset.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam logic [31:0] PC4_VAL = 32'h0000_0104;
    localparam logic [31:0] CSR_VAL = 32'hC5C5_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    writeback_stage_if #(.XLEN(32), .RA_W(5)) tif ();

    writeback_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (tif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [2:0] sel,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu);
        tif.in_valid   = v;
        tif.in_rd      = rd;
        tif.in_sel     = sel;
        tif.in_funct3  = f3;
        tif.in_addr_lo = lo;
        tif.in_alu_out = alu;
    endtask

    task automatic chk_data(input string name, input logic [31:0] exp);
        total_cnt++;
        if (tif.wb_data !== exp) $display("FAIL %s: wb_data got %h want %h", name, tif.wb_data, exp);
        else pass_cnt++;
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %b want %b", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic chk_rd(input string name, input logic [4:0] exp);
        total_cnt++;
        if (tif.wb_rd !== exp) $display("FAIL %s: wb_rd got %0d want %0d", name, tif.wb_rd, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_bit("reset_we", tif.wb_we, 1'b0);
        chk_rd("reset_rd", 5'd0);
        chk_data("reset_data", 32'h0);
        chk_bit("reset_sel_err", tif.sel_err, 1'b0);
        chk_bit("reset_hold_vld", dut.hold_vld_q, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_sources();
        drive(1'b1, 5'd5, WB_ALU, 3'd0, 2'd0, 32'h1234_5678);
        tick();
        drive(1'b1, 5'd6, WB_PC, 3'd0, 2'd0, 32'hAAAA_AAAA);
        chk_bit("alu_we", tif.wb_we, 1'b1);
        chk_rd("alu_rd", 5'd5);
        chk_data("alu_data", 32'h1234_5678);
        tick();
        drive(1'b1, 5'd7, WB_CSR, 3'd0, 2'd0, 32'hAAAA_AAAA);
        chk_rd("pc_rd", 5'd6);
        chk_data("pc_data", PC4_VAL);
        tick();
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        chk_data("csr_data", CSR_VAL);
        chk_bit("csr_we", tif.wb_we, 1'b1);
        tick();
    endtask

    task automatic test_loads();
        drive(1'b1, 5'd8, WB_MEM, F3_LB, 2'd2, 32'h0);
        tick();
        tif.mem_dout = 32'h0080_0000;
        drive(1'b1, 5'd8, WB_MEM, F3_LBU, 2'd2, 32'h0);
        #1 chk_data("lb_sign", 32'hFFFF_FF80);
        tick();
        drive(1'b1, 5'd8, WB_MEM, F3_LH, 2'd2, 32'h0);
        #1 chk_data("lbu_zero", 32'h0000_0080);
        tick();
        tif.mem_dout = 32'h8001_0000;
        drive(1'b1, 5'd8, WB_MEM, F3_LHU, 2'd0, 32'h0);
        #1 chk_data("lh_sign", 32'hFFFF_8001);
        chk_bit("lh_we", tif.wb_we, 1'b1);
        tick();
        tif.mem_dout = 32'h0000_F00D;
        drive(1'b1, 5'd8, WB_MEM, F3_LB, 2'd3, 32'h0);
        #1 chk_data("lhu_zero", 32'h0000_F00D);
        tick();
        tif.mem_dout = 32'h7F00_0000;
        drive(1'b1, 5'd8, WB_MEM, F3_LW, 2'd0, 32'h0);
        #1 chk_data("lb_lane3", 32'h0000_007F);
        chk_bit("b2b_hold_idle", dut.hold_vld_q, 1'b0);
        tick();
        tif.mem_dout = 32'h0BAD_F00D;
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        #1 chk_data("lw_word", 32'h0BAD_F00D);
        chk_bit("lw_hold_idle", dut.hold_vld_q, 1'b0);
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 5'd10, WB_MEM, F3_LW, 2'd0, 32'h0);
        tick();
        tif.mem_dout = 32'hDEAD_BEEF;
        tif.stall    = 1'b1;
        drive(1'b1, 5'd11, WB_ALU, 3'd0, 2'd0, 32'h0000_0999);
        #1 chk_data("stall_c1_data", 32'hDEAD_BEEF);
        chk_bit("stall_c1_we", tif.wb_we, 1'b1);
        tick();
        tif.mem_dout = 32'h0;
        #1 chk_data("stall_c2_data", 32'hDEAD_BEEF);
        chk_bit("stall_c2_hold", dut.hold_vld_q, 1'b1);
        tick();
        #1 chk_data("stall_c3_data", 32'hDEAD_BEEF);
        chk_rd("stall_c3_rd", 5'd10);
        tif.stall = 1'b0;
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        tick();
        chk_bit("stall_release_we", tif.wb_we, 1'b0);
        chk_bit("stall_release_hold", dut.hold_vld_q, 1'b0);
    endtask

    task automatic test_x0_null();
        drive(1'b1, 5'd0, WB_ALU, 3'd0, 2'd0, 32'h0000_CAFE);
        tick();
        drive(1'b1, 5'd7, WB_NULL, 3'd0, 2'd0, 32'h0000_0055);
        chk_bit("x0_we", tif.wb_we, 1'b0);
        chk_data("x0_data", 32'h0000_CAFE);
        tick();
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        chk_bit("null_we", tif.wb_we, 1'b0);
        chk_data("null_data", 32'h0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd12, WB_MEM, F3_LW, 2'd0, 32'h0);
        tick();
        tif.mem_dout = 32'h1111_2222;
        tif.stall    = 1'b1;
        tick();
        tif.mem_dout = 32'h0;
        #1 chk_data("flush_pre_hold_data", 32'h1111_2222);
        tif.flush = 1'b1;
        tick();
        chk_bit("flush_we", tif.wb_we, 1'b0);
        chk_bit("flush_hold_vld", dut.hold_vld_q, 1'b0);
        tif.flush = 1'b0;
        tif.stall = 1'b0;
        drive(1'b1, 5'd9, WB_MEM, F3_LW, 2'd0, 32'h0);
        tick();
        tif.mem_dout = 32'h3333_4444;
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        #1 chk_data("flush_next_live", 32'h3333_4444);
        chk_bit("flush_next_we", tif.wb_we, 1'b1);
        tick();
    endtask

    task automatic test_errors();
        drive(1'b0, 5'd3, 3'd6, 3'd0, 2'd0, 32'h0);
        tick();
        chk_bit("err_invalid_entry", tif.sel_err, 1'b0);
        drive(1'b1, 5'd3, 3'd6, 3'd0, 2'd0, 32'h0000_7777);
        tick();
        drive(1'b1, 5'd4, WB_ALU, 3'd0, 2'd0, 32'h0000_0042);
        chk_bit("err_set", tif.sel_err, 1'b1);
        chk_bit("err_we", tif.wb_we, 1'b0);
        chk_data("err_data", 32'h0);
        tick();
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        chk_bit("err_sticky", tif.sel_err, 1'b1);
        chk_data("err_good_data", 32'h0000_0042);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bit("err_cleared", tif.sel_err, 1'b0);
        // LD is illegal at XLEN=32.
        tif.mem_dout = 32'h1234_5678;
        drive(1'b1, 5'd2, WB_MEM, F3_LD, 2'd0, 32'h0);
        tick();
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        chk_bit("ld_err", tif.sel_err, 1'b1);
        chk_data("ld_data", 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rst_stall();
        drive(1'b1, 5'd13, WB_MEM, F3_LW, 2'd0, 32'h0);
        tick();
        tif.mem_dout = 32'h5555_6666;
        tif.stall    = 1'b1;
        tick();
        chk_bit("rst_stall_hold_set", dut.hold_vld_q, 1'b1);
        rst = 1'b1;
        tick();
        chk_bit("rst_stall_we", tif.wb_we, 1'b0);
        chk_rd("rst_stall_rd", 5'd0);
        chk_data("rst_stall_data", 32'h0);
        chk_bit("rst_stall_hold", dut.hold_vld_q, 1'b0);
        rst       = 1'b0;
        tif.stall = 1'b0;
    endtask

    initial begin
        tif.stall        = 1'b0;
        tif.flush        = 1'b0;
        tif.mem_dout     = 32'h0;
        tif.in_pc_plus_4 = PC4_VAL;
        tif.in_csr_dout  = CSR_VAL;
        drive(1'b0, 5'd0, WB_NULL, 3'd0, 2'd0, 32'h0);
        test_reset();
        test_sources();
        test_loads();
        test_stall();
        test_x0_null();
        test_flush();
        test_errors();
        test_rst_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
